// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: controller states and the
// iteration-counter width helper.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count WIDTH iterations (0 .. WIDTH-1).
    function automatic int count_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift the next dividend bit
// into the partial remainder, try subtracting the divisor, keep the result
// only if it stays non-negative.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   r_in,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] trial_s;
    logic           unused_s;

    // The partial remainder is always below the divisor, so its top bit is
    // never needed in the shift.
    assign unused_s = r_in[WIDTH];

    // Trial subtraction and restore decision.
    always_comb begin
        shifted_s = {r_in[WIDTH-1:0], q_msb};
        trial_s   = shifted_s - {1'b0, d};
        if (trial_s[WIDTH]) begin
            r_out = shifted_s;
            q_bit = 1'b0;
        end else begin
            r_out = trial_s;
            q_bit = 1'b1;
        end
    end

endmodule

// File: rtl/restoring_divider_param.sv
// Parametrised multi-cycle restoring divider, one quotient bit per clock,
// with a start/done handshake and registered results.
// Optional feature macro: SIGNED_DIV_EN (two's complement operands,
// truncating division). Default build is unsigned.
module restoring_divider_param
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int COUNT_W = count_w(WIDTH);

    state_t               state_r;
    state_t               state_s;
    logic [WIDTH:0]       r_r;
    logic [WIDTH-1:0]     q_r;
    logic [WIDTH-1:0]     d_r;
    logic [COUNT_W-1:0]   cnt_r;

    logic [WIDTH:0]       r_step_s;
    logic                 q_bit_s;
    logic [WIDTH-1:0]     q_next_s;
    logic                 last_s;
    logic [WIDTH-1:0]     dvd_mag_s;
    logic [WIDTH-1:0]     dvs_mag_s;
    logic [WIDTH-1:0]     zq_s;
    logic [WIDTH-1:0]     q_fix_s;
    logic [WIDTH-1:0]     r_fix_s;
    logic                 unused_s;

`ifdef SIGNED_DIV_EN
    logic                 sn_r;
    logic                 sd_r;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_in  (r_r),
        .q_msb (q_r[WIDTH-1]),
        .d     (d_r),
        .r_out (r_step_s),
        .q_bit (q_bit_s)
    );

    assign q_next_s = {q_r[WIDTH-2:0], q_bit_s};
    assign last_s   = (cnt_r == COUNT_W'(WIDTH - 1));
    // Remainder sign bits are structurally zero once a step completes.
    assign unused_s = r_step_s[WIDTH];

    // Operand magnitudes, divide-by-zero quotient and final sign correction.
    always_comb begin
`ifdef SIGNED_DIV_EN
        dvd_mag_s = dividend[WIDTH-1] ? -dividend : dividend;
        dvs_mag_s = divisor[WIDTH-1]  ? -divisor  : divisor;
        zq_s      = dividend[WIDTH-1] ? WIDTH'(1) : {WIDTH{1'b1}};
        q_fix_s   = (sn_r ^ sd_r) ? -q_next_s : q_next_s;
        r_fix_s   = sn_r ? -r_step_s[WIDTH-1:0] : r_step_s[WIDTH-1:0];
`else
        dvd_mag_s = dividend;
        dvs_mag_s = divisor;
        zq_s      = {WIDTH{1'b1}};
        q_fix_s   = q_next_s;
        r_fix_s   = r_step_s[WIDTH-1:0];
`endif
    end

    // Controller next-state decision.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = (divisor == '0) ? DONE : CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, datapath and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r     <= IDLE;
            r_r         <= '0;
            q_r         <= '0;
            d_r         <= '0;
            cnt_r       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
            sn_r        <= 1'b0;
            sd_r        <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            busy    <= (state_s != IDLE);
            done    <= (state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= zq_s;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            d_r   <= dvs_mag_s;
                            q_r   <= dvd_mag_s;
                            r_r   <= '0;
                            cnt_r <= '0;
`ifdef SIGNED_DIV_EN
                            sn_r  <= dividend[WIDTH-1];
                            sd_r  <= divisor[WIDTH-1];
`endif
                        end
                    end
                end
                CALC: begin
                    r_r   <= r_step_s;
                    q_r   <= q_next_s;
                    cnt_r <= cnt_r + COUNT_W'(1);
                    if (last_s) begin
                        quotient    <= q_fix_s;
                        remainder   <= r_fix_s;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
